// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: pin sync, 11-bit frame decode with parity/stop check, FWFT code FIFO.
// Define PS2_PREFIX_DECODE_EN to fold F0/E0 prefixes into break/extended flags on the next code.
module ps2_keyboard_rx #(
   parameter int SYNC_STAGES    = 2,
   parameter int FIFO_DEPTH     = 4,
   parameter int TIMEOUT_CYCLES = 5000
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       PS2_CLK,
   input  logic       PS2_DATA,
   input  logic       iRead,
   output logic [7:0] oData,
   output logic       oBreak,
   output logic       oExtended,
   output logic       oValid,
   output logic       oFull,
   output logic       oOverflow,
   output logic       oParityError
);

   localparam int PW = $clog2(FIFO_DEPTH);
   localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
   localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);
   localparam logic [PW:0]   DEPTH_C  = (PW + 1)'(FIFO_DEPTH);
`ifdef PS2_PREFIX_DECODE_EN
   localparam int EW = 10;
`else
   localparam int EW = 8;
`endif

   typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

   logic [SYNC_STAGES-1:0] r_clk_sync;
   logic [SYNC_STAGES-1:0] r_dat_sync;
   logic                   r_clk_prev;
   logic                   r_fall;
   logic                   r_dat_bit;

   // r_dat_bit is delayed one cycle so it lines up with the registered edge strobe
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_clk_sync <= '1;
         r_dat_sync <= '1;
         r_clk_prev <= 1'b1;
         r_fall     <= 1'b0;
         r_dat_bit  <= 1'b1;
      end else begin
         r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], PS2_CLK};
         r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], PS2_DATA};
         r_clk_prev <= r_clk_sync[SYNC_STAGES-1];
         r_fall     <= r_clk_prev & ~r_clk_sync[SYNC_STAGES-1];
         r_dat_bit  <= r_dat_sync[SYNC_STAGES-1];
      end
   end

   state_t          r_state, w_state_nxt;
   logic [2:0]      r_bit_cnt, w_bit_cnt_nxt;
   logic [7:0]      r_shift, w_shift_nxt;
   logic            r_parity, w_parity_nxt;
   logic [TW-1:0]   r_tmo_cnt;
   logic            w_timeout;
   logic            w_good;
   logic            w_bad;
   logic            r_frame_good;
   logic            r_frame_bad;
   logic [7:0]      r_byte;

   always_comb begin
      w_state_nxt   = r_state;
      w_bit_cnt_nxt = r_bit_cnt;
      w_shift_nxt   = r_shift;
      w_parity_nxt  = r_parity;
      w_good        = 1'b0;
      w_bad         = 1'b0;
      w_timeout     = (r_state != S_IDLE) && !r_fall && (r_tmo_cnt == TMO_LAST);
      if (w_timeout) begin
         w_state_nxt = S_IDLE;
      end else if (r_fall) begin
         case (r_state)
            S_IDLE: begin
               if (!r_dat_bit) begin
                  w_state_nxt   = S_DATA;
                  w_bit_cnt_nxt = 3'd0;
               end
            end
            S_DATA: begin
               w_shift_nxt   = {r_dat_bit, r_shift[7:1]};
               w_bit_cnt_nxt = r_bit_cnt + 3'd1;
               if (r_bit_cnt == 3'd7) w_state_nxt = S_PARITY;
            end
            S_PARITY: begin
               w_parity_nxt = r_dat_bit;
               w_state_nxt  = S_STOP;
            end
            S_STOP: begin
               if (r_dat_bit && (^{r_shift, r_parity})) w_good = 1'b1;
               else                                      w_bad  = 1'b1;
               w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_state      <= S_IDLE;
         r_bit_cnt    <= 3'd0;
         r_shift      <= 8'h00;
         r_parity     <= 1'b0;
         r_tmo_cnt    <= '0;
         r_frame_good <= 1'b0;
         r_frame_bad  <= 1'b0;
         r_byte       <= 8'h00;
      end else begin
         r_state      <= w_state_nxt;
         r_bit_cnt    <= w_bit_cnt_nxt;
         r_shift      <= w_shift_nxt;
         r_parity     <= w_parity_nxt;
         r_tmo_cnt    <= (r_state == S_IDLE || r_fall) ? '0 : r_tmo_cnt + 1'b1;
         r_frame_good <= w_good;
         r_frame_bad  <= w_bad;
         if (w_good) r_byte <= r_shift;
      end
   end

   assign oParityError = r_frame_bad;

   logic          w_push;
   logic [EW-1:0] w_push_dat;

`ifdef PS2_PREFIX_DECODE_EN
   logic r_pend_brk;
   logic r_pend_ext;
   logic w_is_prefix;

   assign w_is_prefix = (r_byte == 8'hF0) || (r_byte == 8'hE0);
   assign w_push      = r_frame_good && !w_is_prefix;
   assign w_push_dat  = {r_pend_ext, r_pend_brk, r_byte};

   always_ff @(posedge Clock) begin
      if (Reset || r_frame_bad || w_push) begin
         r_pend_brk <= 1'b0;
         r_pend_ext <= 1'b0;
      end else if (r_frame_good) begin
         if (r_byte == 8'hF0) r_pend_brk <= 1'b1;
         if (r_byte == 8'hE0) r_pend_ext <= 1'b1;
      end
   end
`else
   assign w_push     = r_frame_good;
   assign w_push_dat = r_byte;
`endif

   logic [EW-1:0] r_mem [FIFO_DEPTH];
   logic [PW-1:0] r_wr_ptr;
   logic [PW-1:0] r_rd_ptr;
   logic [PW:0]   r_count;
   logic [EW-1:0] r_last;
   logic          r_overflow;
   logic          w_pop;
   logic          w_full;
   logic          w_write;
   logic [EW-1:0] w_head;

   assign w_full  = (r_count == DEPTH_C);
   assign oValid  = (r_count != '0);
   assign w_pop   = iRead && oValid;
   assign w_write = w_push && (!w_full || w_pop);

   always_ff @(posedge Clock) begin
      if (w_write) r_mem[r_wr_ptr] <= w_push_dat;
   end

   // r_last keeps the most recently popped entry visible while the FIFO is empty
   always_ff @(posedge Clock) begin
      if (Reset) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_count    <= '0;
         r_last     <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_write) r_wr_ptr <= r_wr_ptr + 1'b1;
         if (w_pop) begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
            r_last   <= r_mem[r_rd_ptr];
         end
         case ({w_write, w_pop})
            2'b10:   r_count <= r_count + 1'b1;
            2'b01:   r_count <= r_count - 1'b1;
            default: r_count <= r_count;
         endcase
         if (w_push && w_full && !w_pop) r_overflow <= 1'b1;
      end
   end

   assign w_head    = oValid ? r_mem[r_rd_ptr] : r_last;
   assign oData     = w_head[7:0];
   assign oFull     = w_full;
   assign oOverflow = r_overflow;
`ifdef PS2_PREFIX_DECODE_EN
   assign oBreak    = w_head[8];
   assign oExtended = w_head[9];
`else
   assign oBreak    = 1'b0;
   assign oExtended = 1'b0;
`endif

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Randomised bench for ps2_keyboard_rx against a frame-level reference model (honours PS2_PREFIX_DECODE_EN).
module tb_ps2_keyboard_rx;
   localparam int DEPTH = 4;

   logic       Clock = 1'b0;
   logic       Reset = 1'b0;
   logic       PS2_CLK = 1'b1;
   logic       PS2_DATA = 1'b1;
   logic       iRead = 1'b0;
   logic [7:0] oData;
   logic       oBreak, oExtended, oValid, oFull, oOverflow, oParityError;

   ps2_keyboard_rx #(.SYNC_STAGES(2), .FIFO_DEPTH(DEPTH), .TIMEOUT_CYCLES(100)) dut (
      .Clock(Clock), .Reset(Reset), .PS2_CLK(PS2_CLK), .PS2_DATA(PS2_DATA), .iRead(iRead),
      .oData(oData), .oBreak(oBreak), .oExtended(oExtended), .oValid(oValid),
      .oFull(oFull), .oOverflow(oOverflow), .oParityError(oParityError)
   );

   always #5 Clock = ~Clock;

   int checks = 0;
   int errors = 0;
   int perr_seen = 0;
   int perr_exp = 0;

   logic [9:0] mq[$];
   bit m_brk, m_ext, m_ovf;

   always @(negedge Clock) if (oParityError === 1'b1) perr_seen++;

   task automatic tick(input int n);
      repeat (n) begin @(posedge Clock); #1; end
   endtask

   function automatic logic [10:0] frame(input logic [7:0] b, input bit bad_par);
      logic p;
      p = (~^b) ^ bad_par;
      return {1'b1, p, b, 1'b0};
   endfunction

   task automatic model_push(input logic [9:0] e);
      if (mq.size() < DEPTH) mq.push_back(e);
      else m_ovf = 1'b1;
   endtask

   task automatic model_frame(input logic [7:0] b, input bit good);
      if (!good) begin
         m_brk = 1'b0; m_ext = 1'b0; perr_exp++;
      end else begin
`ifdef PS2_PREFIX_DECODE_EN
         if (b == 8'hF0) m_brk = 1'b1;
         else if (b == 8'hE0) m_ext = 1'b1;
         else begin
            model_push({m_ext, m_brk, b});
            m_brk = 1'b0; m_ext = 1'b0;
         end
`else
         model_push({2'b00, b});
`endif
      end
   endtask

   // Device-side bit clocking; optionally pulses iRead in the cycle the stop-bit byte is pushed.
   task automatic send_bits(input logic [10:0] bits, input int n, input bit pop_stop);
      int half;
      half = $urandom_range(6, 10);
      for (int i = 0; i < n; i++) begin
         PS2_DATA = bits[i];
         tick(half);
         PS2_CLK = 1'b0;
         for (int j = 1; j <= half; j++) begin
            tick(1);
            if (pop_stop && i == 10) begin
               if (j == 4) iRead = 1'b1;
               else if (j == 5) iRead = 1'b0;
            end
         end
         PS2_CLK = 1'b1;
      end
      tick(half);
      PS2_DATA = 1'b1;
   endtask

   task automatic send_byte(input logic [7:0] b, input bit bad_par);
      send_bits(frame(b, bad_par), 11, 1'b0);
      model_frame(b, !bad_par);
      tick(4);
   endtask

   task automatic pop_head(output logic [9:0] got, output logic vld);
      got = {oExtended, oBreak, oData};
      vld = oValid;
      iRead = 1'b1; tick(1); iRead = 1'b0; tick(1);
   endtask

   task automatic do_reset();
      Reset = 1'b1; tick(1); Reset = 1'b0;
      mq.delete(); m_brk = 1'b0; m_ext = 1'b0; m_ovf = 1'b0;
   endtask

   task automatic test_reset();
      logic [13:0] obs;
      Reset = 1'b1; tick(3); Reset = 1'b0;
      mq.delete(); m_brk = 1'b0; m_ext = 1'b0; m_ovf = 1'b0;
      obs = {oData, oBreak, oExtended, oValid, oFull, oOverflow, oParityError};
      checks++;
      if (obs !== 14'h0) begin errors++; $display("FAIL reset_values got %h want 0000", obs); end
   endtask

   task automatic test_make();
      logic [9:0] exp;
      do_reset();
      send_byte(8'h1C, 1'b0);
      exp = mq.pop_front();
      checks++;
      if (oValid !== 1'b1 || {oExtended, oBreak, oData} !== exp)
         begin errors++; $display("FAIL make_head got vld=%b %h want vld=1 %h", oValid, {oExtended, oBreak, oData}, exp); end
      iRead = 1'b1; tick(1); iRead = 1'b0; tick(1);
      checks++;
      if (oValid !== 1'b0) begin errors++; $display("FAIL make_pop_valid got %b want 0", oValid); end
      checks++;
      if (oData !== 8'h1C) begin errors++; $display("FAIL make_hold_data got %h want 1c", oData); end
   endtask

   task automatic test_prefix();
      logic [9:0] exp, got; logic vld;
      do_reset();
      send_byte(8'hF0, 1'b0); send_byte(8'h1C, 1'b0);
      while (mq.size() > 0) begin
         exp = mq.pop_front(); pop_head(got, vld); checks++;
         if (vld !== 1'b1 || got !== exp) begin errors++; $display("FAIL prefix_f0 got vld=%b %h want %h", vld, got, exp); end
      end
      send_byte(8'hE0, 1'b0); send_byte(8'hF0, 1'b0); send_byte(8'h75, 1'b0);
      while (mq.size() > 0) begin
         exp = mq.pop_front(); pop_head(got, vld); checks++;
         if (vld !== 1'b1 || got !== exp) begin errors++; $display("FAIL prefix_e0f0 got vld=%b %h want %h", vld, got, exp); end
      end
      checks++;
      if (oValid !== 1'b0) begin errors++; $display("FAIL prefix_empty got %b want 0", oValid); end
   endtask

   task automatic test_parity();
      logic [9:0] exp, got; logic vld;
      do_reset();
      send_byte(8'hF0, 1'b0);
      send_byte(8'h1C, 1'b1);
      checks++;
      if (perr_seen !== perr_exp) begin errors++; $display("FAIL parity_pulse got %0d cycles want %0d", perr_seen, perr_exp); end
      checks++;
      if (oValid !== (mq.size() != 0)) begin errors++; $display("FAIL parity_nopush got vld=%b want %b", oValid, mq.size() != 0); end
      send_bits(frame(8'h3A, 1'b0) & 11'h3FF, 11, 1'b0);
      model_frame(8'h3A, 1'b0);
      tick(4);
      checks++;
      if (perr_seen !== perr_exp) begin errors++; $display("FAIL stop_pulse got %0d cycles want %0d", perr_seen, perr_exp); end
      send_byte(8'h1C, 1'b0);
      while (mq.size() > 0) begin
         exp = mq.pop_front(); pop_head(got, vld); checks++;
         if (vld !== 1'b1 || got !== exp) begin errors++; $display("FAIL parity_after got vld=%b %h want %h", vld, got, exp); end
      end
   endtask

   task automatic test_overflow();
      logic [9:0] exp, got; logic vld;
      logic [7:0] codes [5];
      codes = '{8'h16, 8'h1E, 8'h26, 8'h25, 8'h2E};
      do_reset();
      for (int i = 0; i < 4; i++) send_byte(codes[i], 1'b0);
      checks++;
      if (oFull !== 1'b1 || oOverflow !== 1'b0) begin errors++; $display("FAIL ovf_full got full=%b ovf=%b want 1 0", oFull, oOverflow); end
      send_byte(codes[4], 1'b0);
      checks++;
      if (oOverflow !== m_ovf) begin errors++; $display("FAIL ovf_set got %b want %b", oOverflow, m_ovf); end
      while (mq.size() > 0) begin
         exp = mq.pop_front(); pop_head(got, vld); checks++;
         if (vld !== 1'b1 || got !== exp) begin errors++; $display("FAIL ovf_drain got vld=%b %h want %h", vld, got, exp); end
      end
      checks++;
      if (oOverflow !== 1'b1 || oValid !== 1'b0) begin errors++; $display("FAIL ovf_sticky got ovf=%b vld=%b want 1 0", oOverflow, oValid); end
      do_reset();
      checks++;
      if (oOverflow !== 1'b0) begin errors++; $display("FAIL ovf_clear got %b want 0", oOverflow); end
   endtask

   task automatic test_back_to_back();
      logic [9:0] exp, got; logic vld;
      logic [7:0] codes [4];
      codes = '{8'h16, 8'h1E, 8'h26, 8'h25};
      do_reset();
      for (int i = 0; i < 4; i++) send_byte(codes[i], 1'b0);
      send_bits(frame(8'h2E, 1'b0), 11, 1'b1);
      void'(mq.pop_front());
      model_frame(8'h2E, 1'b1);
      tick(4);
      checks++;
      if (oFull !== 1'b1 || oOverflow !== 1'b0) begin errors++; $display("FAIL simul_occupancy got full=%b ovf=%b want 1 0", oFull, oOverflow); end
      while (mq.size() > 0) begin
         exp = mq.pop_front(); pop_head(got, vld); checks++;
         if (vld !== 1'b1 || got !== exp) begin errors++; $display("FAIL simul_drain got vld=%b %h want %h", vld, got, exp); end
      end
   endtask

   task automatic test_timeout();
      logic [9:0] exp, got; logic vld;
      logic [10:0] part;
      do_reset();
      part = 11'($urandom) & 11'h7FE;
      send_bits(part, 4, 1'b0);
      tick(150);
      send_byte(8'h1C, 1'b0);
      checks++;
      if (perr_seen !== perr_exp) begin errors++; $display("FAIL timeout_perr got %0d want %0d", perr_seen, perr_exp); end
      while (mq.size() > 0) begin
         exp = mq.pop_front(); pop_head(got, vld); checks++;
         if (vld !== 1'b1 || got !== exp) begin errors++; $display("FAIL timeout_entry got vld=%b %h want %h", vld, got, exp); end
      end
      checks++;
      if (oValid !== 1'b0) begin errors++; $display("FAIL timeout_single got %b want 0", oValid); end
   endtask

   task automatic test_reset_midframe();
      logic [9:0] exp, got; logic vld;
      logic [13:0] obs;
      logic [10:0] part;
      do_reset();
      send_byte(8'h16, 1'b0);
      part = 11'($urandom) & 11'h7FE;
      send_bits(part, 5, 1'b0);
      do_reset();
      obs = {oData, oBreak, oExtended, oValid, oFull, oOverflow, oParityError};
      checks++;
      if (obs !== 14'h0) begin errors++; $display("FAIL midreset_values got %h want 0000", obs); end
      send_byte(8'h1C, 1'b0);
      while (mq.size() > 0) begin
         exp = mq.pop_front(); pop_head(got, vld); checks++;
         if (vld !== 1'b1 || got !== exp) begin errors++; $display("FAIL midreset_frame got vld=%b %h want %h", vld, got, exp); end
      end
   endtask

   task automatic test_random();
      logic [9:0] exp, got; logic vld;
      logic [7:0] b;
      int r;
      do_reset();
      for (int n = 0; n < 40; n++) begin
         r = $urandom_range(0, 9);
         b = (r < 2) ? 8'hF0 : (r == 2) ? 8'hE0 : 8'($urandom);
         send_byte(b, $urandom_range(0, 7) == 0);
         if ($urandom_range(0, 2) == 0 && mq.size() > 0) begin
            exp = mq.pop_front(); pop_head(got, vld); checks++;
            if (vld !== 1'b1 || got !== exp) begin errors++; $display("FAIL random_pop got vld=%b %h want %h", vld, got, exp); end
         end
      end
      checks++;
      if (oOverflow !== m_ovf || perr_seen !== perr_exp)
         begin errors++; $display("FAIL random_flags got ovf=%b perr=%0d want %b %0d", oOverflow, perr_seen, m_ovf, perr_exp); end
      while (mq.size() > 0) begin
         exp = mq.pop_front(); pop_head(got, vld); checks++;
         if (vld !== 1'b1 || got !== exp) begin errors++; $display("FAIL random_drain got vld=%b %h want %h", vld, got, exp); end
      end
   endtask

   initial begin
      tick(2);
      test_reset();
      test_make();
      test_prefix();
      test_parity();
      test_overflow();
      test_back_to_back();
      test_timeout();
      test_reset_midframe();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
